dso_capture_ctrl: RTL

Acquisition controller for the scope sample buffer.
- Divides the system clock into a sample tick and writes ADC samples into a circular RAM of 2^AW words through an internal address counter.
- Runs a pre-trigger fill, waits for a level-crossing or forced trigger, then completes the post-trigger window.
- Reports the trigger address and the readout start address to the readout path.
- Sits between the ADC capture register and the sample RAM write port.

---
 rtl/dso_capture_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dso_capture_ctrl.sv
// Scope acquisition controller: divides clk into sample ticks, writes ADC samples into a
// circular buffer, runs pre-trigger fill, trigger search and post-trigger window.
module dso_capture_ctrl #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 10,
    parameter int unsigned DIVW = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            arm,
    input  logic            force_req,
    input  logic [DIVW-1:0] div,
    input  logic [AW-1:0]   pre_len,
    input  logic [DW-1:0]   trig_level,
    input  logic            trig_edge,
    input  logic [DW-1:0]   adc_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [AW-1:0]   trig_addr,
    output logic [AW-1:0]   start_addr,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_cnt_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   pre_cnt_q;
    logic [AW-1:0]   post_cnt_q;
    logic [DW-1:0]   prev_q;
    logic            prev_valid_q;
    logic            force_pend_q;

    logic            busy_st;
    logic            tick;
    logic            crossing;
    logic            fire;
    logic [AW-1:0]   post_init;

    always_comb begin
        busy_st   = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
        tick      = busy_st && (div_cnt_q == div);
        post_init = ~pre_len;
        if (trig_edge) begin
            crossing = (prev_q > trig_level) && (adc_data <= trig_level);
        end else begin
            crossing = (prev_q < trig_level) && (adc_data >= trig_level);
        end
        // A pending force fires even before any previous sample exists.
        fire = (state_q == StWait) && tick && (force_pend_q || (prev_valid_q && crossing));

        state_d = state_q;
        if (arm) begin
            state_d = (pre_len == '0) ? StWait : StPre;
        end else begin
            unique case (state_q)
                StPre: begin
                    if (tick && (pre_cnt_q + 1'b1 == pre_len)) state_d = StWait;
                end
                StWait: begin
                    if (fire) state_d = (post_init == '0) ? StDone : StPost;
                end
                StPost: begin
                    if (tick && (post_cnt_q == AW'(1))) state_d = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt_q    <= '0;
            addr_q       <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            trig_addr    <= '0;
            start_addr   <= '0;
        end else if (arm) begin
            div_cnt_q    <= '0;
            addr_q       <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            wr_en        <= 1'b0;
            trig_addr    <= '0;
            start_addr   <= '0;
        end else begin
            wr_en <= tick;
            if (busy_st) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
            end else begin
                div_cnt_q <= '0;
            end
            if (tick) begin
                wr_addr      <= addr_q;
                wr_data      <= adc_data;
                addr_q       <= addr_q + 1'b1;
                prev_q       <= adc_data;
                prev_valid_q <= 1'b1;
            end
            if ((state_q == StPre) && tick) pre_cnt_q <= pre_cnt_q + 1'b1;
            if (force_req && ((state_q == StPre) || (state_q == StWait))) force_pend_q <= 1'b1;
            if (fire) begin
                trig_addr    <= addr_q;
                start_addr   <= addr_q - pre_len;
                post_cnt_q   <= post_init;
                force_pend_q <= 1'b0;
            end
            if ((state_q == StPost) && tick) post_cnt_q <= post_cnt_q - 1'b1;
        end
    end

    assign busy = busy_st;
    assign done = (state_q == StDone);

endmodule
